hawk_pgrd_mngr_mc: RTL and testbench

//  Multi-channel page-read manager: arbitrates N lookup channels round-robin and walks the ATT over single-beat AXI reads.
//  On miss, allocates a way from the free list; on compressed pages, hands off to the decompressor; then requests the table update.

---
 rtl/hawk_pgrd_mngr_mc.sv | 244 ++++++++++++++++++++++++
 tb/tb_hawk_pgrd_mngr_mc.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_pgrd_mngr_mc.sv
// Multi-channel page-read manager: round-robin lookup arbiter, ATT/TOL walk over
// single-beat AXI reads, free-list allocation, decompression hand-off and table update.
module hawk_pgrd_mngr_mc #(
  parameter int unsigned      NUM_CH       = 4,
  parameter int unsigned      PPN_W        = 28,
  parameter int unsigned      ID_W         = 16,
  parameter logic [63:0]      ATT_BASE     = 64'h0,
  parameter logic [63:0]      TOL_BASE     = 64'h0,
  parameter logic [PPN_W-1:0] HPPA_BASE_PN = PPN_W'('h80000),
  parameter int unsigned      RD_TIMEOUT   = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       lkup_vld_i,
  input  logic [NUM_CH*PPN_W-1:0] lkup_hppa_i,
  output logic [NUM_CH-1:0]       lkup_ack_o,
  output logic [NUM_CH-1:0]       resp_vld_o,
  output logic [PPN_W-1:0]        resp_ppn_o,
  output logic [1:0]              resp_sts_o,
  output logic [63:0]             araddr_o,
  output logic [7:0]              arlen_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [63:0]             rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rvalid_i,
  input  logic                    rlast_i,
  output logic                    rready_o,
  input  logic [ID_W-1:0]         free_head_i,
  input  logic                    pwm_ready_i,
  output logic                    tbl_upd_o,
  output logic [ID_W-1:0]         tbl_id_o,
  output logic [PPN_W-1:0]        tbl_ppn_o,
  input  logic                    tbl_done_i,
  output logic                    decomp_req_o,
  output logic [PPN_W-1:0]        decomp_cppn_o,
  output logic [PPN_W-1:0]        decomp_way_o,
  input  logic                    decomp_done_i,
  output logic                    ready_o,
  output logic                    oom_o,
  output logic                    bus_err_o,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             alloc_cnt_o
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TMO_W = $clog2(RD_TIMEOUT) + 1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ATT_AR   = 4'd1;
  localparam logic [3:0] S_ATT_R    = 4'd2;
  localparam logic [3:0] S_CHK      = 4'd3;
  localparam logic [3:0] S_FREE_CHK = 4'd4;
  localparam logic [3:0] S_TOL_AR   = 4'd5;
  localparam logic [3:0] S_TOL_R    = 4'd6;
  localparam logic [3:0] S_DECOMP   = 4'd7;
  localparam logic [3:0] S_UPD      = 4'd8;
  localparam logic [3:0] S_UPD_W    = 4'd9;
  localparam logic [3:0] S_RESP     = 4'd10;
  localparam logic [3:0] S_BUS_ERR  = 4'd11;

  localparam logic [1:0] STS_DALLOC = 2'd0;
  localparam logic [1:0] STS_UNCOMP = 2'd1;
  localparam logic [1:0] STS_COMP   = 2'd2;
  localparam logic [1:0] STS_INCOMP = 2'd3;

  logic [3:0]       state_q, state_d;
  logic [CH_W-1:0]  rr_q, rr_d, ch_q, ch_d, gnt, idx;
  logic             gnt_vld;
  logic [PPN_W-1:0] hppa_sel;
  logic [ID_W-1:0]  id_q, id_d;
  logic [1:0]       sts_q, sts_d;
  logic [PPN_W-1:0] ppn_q, ppn_d, way_q, way_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [63:0]      araddr_d;
  logic [PPN_W-1:0] resp_ppn_d;
  logic [1:0]       resp_sts_d;
  logic             oom_d, tbl_upd_d;
  logic [31:0]      hit_d, alloc_d;
  logic             unused_rdata;

  assign arlen_o       = 8'h0;
  assign tbl_id_o      = id_q;
  assign tbl_ppn_o     = way_q;
  assign decomp_cppn_o = ppn_q;
  assign decomp_way_o  = way_q;
  assign unused_rdata  = ^{rdata_i[63:PPN_W+12], rdata_i[11:2]};

  // Next-state, datapath and grant logic; lkup_ack_o is the same-cycle grant pulse
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    ch_d       = ch_q;
    id_d       = id_q;
    sts_d      = sts_q;
    ppn_d      = ppn_q;
    way_d      = way_q;
    tmo_d      = tmo_q;
    araddr_d   = araddr_o;
    resp_ppn_d = resp_ppn_o;
    resp_sts_d = resp_sts_o;
    oom_d      = oom_o;
    hit_d      = hit_cnt_o;
    alloc_d    = alloc_cnt_o;
    tbl_upd_d  = 1'b0;
    lkup_ack_o = '0;
    gnt_vld    = 1'b0;
    gnt        = '0;
    idx        = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      idx = CH_W'((int'(rr_q) + i) % int'(NUM_CH));
      if (!gnt_vld && lkup_vld_i[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
    hppa_sel = lkup_hppa_i[int'(gnt)*int'(PPN_W) +: PPN_W];

    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          lkup_ack_o[gnt] = 1'b1;
          ch_d     = gnt;
          id_d     = ID_W'(hppa_sel - HPPA_BASE_PN + PPN_W'(1));
          rr_d     = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
          araddr_d = ATT_BASE + (64'(id_d) << 3);
          state_d  = S_ATT_AR;
        end
      end
      S_ATT_AR, S_TOL_AR: begin
        if (arready_i) begin
          tmo_d   = '0;
          state_d = (state_q == S_ATT_AR) ? S_ATT_R : S_TOL_R;
        end
      end
      S_ATT_R, S_TOL_R: begin
        if (rvalid_i && rlast_i) begin
          if (rresp_i != 2'b00) begin
            state_d = S_BUS_ERR;
          end else if (state_q == S_ATT_R) begin
            sts_d   = rdata_i[1:0];
            ppn_d   = rdata_i[PPN_W+11:12];
            state_d = S_CHK;
          end else begin
            way_d   = rdata_i[PPN_W+11:12];
            alloc_d = (alloc_cnt_o == 32'hFFFF_FFFF) ? alloc_cnt_o : alloc_cnt_o + 32'd1;
            state_d = (sts_q == STS_COMP) ? S_DECOMP : S_UPD;
          end
        end else if (!rvalid_i) begin
          if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) state_d = S_BUS_ERR;
          else                                 tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      S_CHK: begin
        if (sts_q == STS_UNCOMP || sts_q == STS_INCOMP) begin
          resp_ppn_d = ppn_q;
          resp_sts_d = sts_q;
          hit_d      = (hit_cnt_o == 32'hFFFF_FFFF) ? hit_cnt_o : hit_cnt_o + 32'd1;
          state_d    = S_RESP;
        end else begin
          state_d = S_FREE_CHK;
        end
      end
      S_FREE_CHK: begin
        if (free_head_i == '0) begin
          oom_d      = 1'b1;
          resp_ppn_d = '0;
          resp_sts_d = STS_DALLOC;
          state_d    = S_RESP;
        end else begin
          araddr_d = TOL_BASE + (64'(free_head_i) << 3);
          state_d  = S_TOL_AR;
        end
      end
      S_DECOMP: if (decomp_done_i) state_d = S_UPD;
      S_UPD: begin
        if (pwm_ready_i) begin
          tbl_upd_d = 1'b1;
          state_d   = S_UPD_W;
        end
      end
      S_UPD_W: begin
        if (tbl_done_i) begin
          resp_ppn_d = way_q;
          resp_sts_d = STS_UNCOMP;
          state_d    = S_RESP;
        end
      end
      S_RESP:    state_d = S_IDLE;
      S_BUS_ERR: state_d = S_BUS_ERR;
      default:   state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered state-decoded outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      ch_q         <= '0;
      id_q         <= '0;
      sts_q        <= '0;
      ppn_q        <= '0;
      way_q        <= '0;
      tmo_q        <= '0;
      araddr_o     <= '0;
      resp_ppn_o   <= '0;
      resp_sts_o   <= '0;
      oom_o        <= 1'b0;
      hit_cnt_o    <= '0;
      alloc_cnt_o  <= '0;
      tbl_upd_o    <= 1'b0;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
      decomp_req_o <= 1'b0;
      ready_o      <= 1'b1;
      bus_err_o    <= 1'b0;
      resp_vld_o   <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      ch_q         <= ch_d;
      id_q         <= id_d;
      sts_q        <= sts_d;
      ppn_q        <= ppn_d;
      way_q        <= way_d;
      tmo_q        <= tmo_d;
      araddr_o     <= araddr_d;
      resp_ppn_o   <= resp_ppn_d;
      resp_sts_o   <= resp_sts_d;
      oom_o        <= oom_d;
      hit_cnt_o    <= hit_d;
      alloc_cnt_o  <= alloc_d;
      tbl_upd_o    <= tbl_upd_d;
      arvalid_o    <= (state_d == S_ATT_AR) || (state_d == S_TOL_AR);
      rready_o     <= (state_d == S_ATT_R) || (state_d == S_TOL_R);
      decomp_req_o <= (state_d == S_DECOMP);
      ready_o      <= (state_d == S_IDLE);
      bus_err_o    <= (state_d == S_BUS_ERR);
      resp_vld_o   <= (state_d == S_RESP) ? (NUM_CH'(1) << ch_d) : '0;
    end
  end

endmodule

// File: tb/tb_hawk_pgrd_mngr_mc.sv
// Scoreboard bench for hawk_pgrd_mngr_mc: directed lookups with AXI, PWM and
// decompressor models; responses are checked by an independent monitor.
module tb_hawk_pgrd_mngr_mc;
  localparam int unsigned NUM_CH = 4, PPN_W = 28, ID_W = 16, RD_TIMEOUT = 16;

  typedef struct { int ch; logic [PPN_W-1:0] ppn; logic [1:0] sts; } exp_t;
  typedef struct { int ch; logic [PPN_W-1:0] hppa; } req_t;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [NUM_CH-1:0] lkup_vld_i, lkup_ack_o, resp_vld_o;
  logic [NUM_CH*PPN_W-1:0] lkup_hppa_i;
  logic [PPN_W-1:0] resp_ppn_o, tbl_ppn_o, decomp_cppn_o, decomp_way_o;
  logic [1:0] resp_sts_o, rresp_i;
  logic [63:0] araddr_o, rdata_i;
  logic [7:0] arlen_o;
  logic arvalid_o, arready_i, rvalid_i, rlast_i, rready_o;
  logic [ID_W-1:0] free_head_i, tbl_id_o;
  logic pwm_ready_i, tbl_upd_o, tbl_done_i, decomp_req_o, decomp_done_i;
  logic ready_o, oom_o, bus_err_o;
  logic [31:0] hit_cnt_o, alloc_cnt_o;

  hawk_pgrd_mngr_mc #(.NUM_CH(NUM_CH), .PPN_W(PPN_W), .ID_W(ID_W), .ATT_BASE(64'h0),
    .TOL_BASE(64'h0), .HPPA_BASE_PN(28'h80000), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .lkup_vld_i(lkup_vld_i), .lkup_hppa_i(lkup_hppa_i),
    .lkup_ack_o(lkup_ack_o), .resp_vld_o(resp_vld_o), .resp_ppn_o(resp_ppn_o),
    .resp_sts_o(resp_sts_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arvalid_o(arvalid_o),
    .arready_i(arready_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i),
    .rlast_i(rlast_i), .rready_o(rready_o), .free_head_i(free_head_i),
    .pwm_ready_i(pwm_ready_i), .tbl_upd_o(tbl_upd_o), .tbl_id_o(tbl_id_o),
    .tbl_ppn_o(tbl_ppn_o), .tbl_done_i(tbl_done_i), .decomp_req_o(decomp_req_o),
    .decomp_cppn_o(decomp_cppn_o), .decomp_way_o(decomp_way_o),
    .decomp_done_i(decomp_done_i), .ready_o(ready_o), .oom_o(oom_o),
    .bus_err_o(bus_err_o), .hit_cnt_o(hit_cnt_o), .alloc_cnt_o(alloc_cnt_o));

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0, total_cnt = 0, cyc = 0;
  int ack_cyc = 0, resp_cyc = 0, err_cyc = 0;
  exp_t exp_q[$];
  req_t req_q[$], keep_q[$];
  int ack_log[$];
  logic [63:0] ar_log[$];
  logic [ID_W+PPN_W-1:0] upd_log[$];
  logic [63:0] mem [logic [63:0]];
  logic err_mode = 1'b0, mute = 1'b0, pend = 1'b0, done_pend = 1'b0;
  logic [63:0] pend_addr;
  int dec_run = 0, dec_max_run = 0;
  logic dec_unstable = 1'b0;
  logic [PPN_W-1:0] dec_cppn = '0, dec_way = '0;
  logic [NUM_CH-1:0] acked;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Requesters: hold lkup_vld_i until acked, then drop it after the granting edge
  initial begin
    req_t r;
    lkup_vld_i = '0;
    lkup_hppa_i = '0;
    forever begin
      @(negedge clk_i);
      acked = lkup_ack_o;
      if (acked != '0) begin
        ack_cyc = cyc;
        for (int c = 0; c < int'(NUM_CH); c++) if (acked[c]) ack_log.push_back(c);
      end
      @(posedge clk_i);
      #1;
      lkup_vld_i = lkup_vld_i & ~acked;
      keep_q.delete();
      while (req_q.size() > 0) begin
        r = req_q.pop_front();
        if (!lkup_vld_i[r.ch]) begin
          lkup_vld_i[r.ch] = 1'b1;
          lkup_hppa_i[r.ch*PPN_W +: PPN_W] = r.hppa;
        end else keep_q.push_back(r);
      end
      req_q = keep_q;
    end
  end

  // AXI read slave: always ready, one beat on the cycle after the address handshake
  initial begin
    arready_i = 1'b1; rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00; rdata_i = '0;
    forever begin
      @(negedge clk_i);
      rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00;
      if (!rst_ni) pend = 1'b0;
      if (pend) begin
        rvalid_i = 1'b1; rlast_i = 1'b1;
        rdata_i = mem.exists(pend_addr) ? mem[pend_addr] : 64'h0;
        rresp_i = err_mode ? 2'b10 : 2'b00;
        pend = 1'b0;
      end
      if (rst_ni && arvalid_o && arready_i) begin
        ar_log.push_back(araddr_o);
        pend = !mute;
        pend_addr = araddr_o;
      end
    end
  end

  // PWM and decompressor models
  initial begin
    pwm_ready_i = 1'b1; tbl_done_i = 1'b0; decomp_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      tbl_done_i = 1'b0; decomp_done_i = 1'b0;
      if (done_pend) begin tbl_done_i = 1'b1; done_pend = 1'b0; end
      if (tbl_upd_o) begin upd_log.push_back({tbl_id_o, tbl_ppn_o}); done_pend = 1'b1; end
      if (decomp_req_o) begin
        dec_run++;
        if (dec_run == 1) begin dec_cppn = decomp_cppn_o; dec_way = decomp_way_o; end
        else if (decomp_cppn_o !== dec_cppn || decomp_way_o !== dec_way) dec_unstable = 1'b1;
        if (dec_run > dec_max_run) dec_max_run = dec_run;
        if (dec_run == 4) decomp_done_i = 1'b1;
      end else dec_run = 0;
    end
  end

  // Response monitor: pops the scoreboard whenever any resp_vld_o bit is set
  initial begin
    exp_t e;
    logic [NUM_CH-1:0] oh;
    forever begin
      @(negedge clk_i);
      if (resp_vld_o != '0) begin
        resp_cyc = cyc;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL resp_unexpected: got resp_vld=%b with nothing expected", resp_vld_o);
        end else begin
          e = exp_q.pop_front();
          oh = '0;
          oh[e.ch] = 1'b1;
          chk("resp_vld", 64'(resp_vld_o), 64'(oh));
          chk("resp_ppn", 64'(resp_ppn_o), 64'(e.ppn));
          chk("resp_sts", 64'(resp_sts_o), 64'(e.sts));
        end
      end
    end
  end

  task automatic issue(input int ch, input logic [PPN_W-1:0] hppa);
    req_t r;
    r.ch = ch; r.hppa = hppa;
    req_q.push_back(r);
  endtask

  task automatic expect_resp(input int ch, input logic [PPN_W-1:0] ppn, input logic [1:0] sts);
    exp_t e;
    e.ch = ch; e.ppn = ppn; e.sts = sts;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((exp_q.size() != 0 || req_q.size() != 0 || lkup_vld_i != '0 || !ready_o) && n < 300);
    if (n >= 300) begin
      total_cnt++;
      $display("FAIL %s: still busy after %0d cycles, %0d responses outstanding", name, n, exp_q.size());
    end
  endtask

  task automatic wait_bus_err(input string name);
    int n;
    n = 0;
    while (!bus_err_o && n < 60) begin @(negedge clk_i); n++; end
    err_cyc = cyc;
    chk(name, 64'(bus_err_o), 64'h1);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ready"}, 64'(ready_o), 64'h1);
    chk({name, "_ctrl"}, 64'({arvalid_o, rready_o, tbl_upd_o, decomp_req_o, bus_err_o, oom_o}), 64'h0);
    chk({name, "_resp"}, 64'({resp_vld_o, lkup_ack_o, arlen_o}), 64'h0);
    chk({name, "_cnts"}, {hit_cnt_o, alloc_cnt_o}, 64'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    free_head_i = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    check_reset("reset0");

    // Direct hit on ch2, id 6
    mem[64'h30] = (64'h1234 << 12) | 64'h1;
    ar_log.delete();
    issue(2, 28'h80005);
    expect_resp(2, 28'h1234, 2'd1);
    wait_idle("hit_ch2");
    chk("hit_araddr", (ar_log.size() == 1) ? ar_log[0] : 64'hDEAD, 64'h30);
    chk("hit_latency", 64'(resp_cyc - ack_cyc), 64'd4);
    chk("hit_cnt1", 64'(hit_cnt_o), 64'd1);

    // All channels requesting, ch0 re-requests immediately
    do_reset();
    mem[64'h10] = (64'h100 << 12) | 64'h1;
    mem[64'h18] = (64'h101 << 12) | 64'h3;
    mem[64'h20] = (64'h102 << 12) | 64'h1;
    mem[64'h28] = (64'h103 << 12) | 64'h3;
    ack_log.delete();
    for (int c = 0; c < 4; c++) issue(c, 28'h80001 + 28'(c));
    issue(0, 28'h80001);
    expect_resp(0, 28'h100, 2'd1);
    expect_resp(1, 28'h101, 2'd3);
    expect_resp(2, 28'h102, 2'd1);
    expect_resp(3, 28'h103, 2'd3);
    expect_resp(0, 28'h100, 2'd1);
    wait_idle("rr_all");
    chk("rr_ack_count", 64'(ack_log.size()), 64'd5);
    if (ack_log.size() == 5) begin
      chk("rr_order", 64'({4'(ack_log[0]), 4'(ack_log[1]), 4'(ack_log[2]), 4'(ack_log[3]), 4'(ack_log[4])}),
          64'h01230);
    end
    chk("hit_cnt5", 64'(hit_cnt_o), 64'd5);

    // DALLOC entry, allocation from free head 7, no decompression
    mem[64'h88] = 64'h0;
    mem[64'h38] = 64'h55 << 12;
    free_head_i = 16'd7;
    ar_log.delete(); upd_log.delete();
    issue(1, 28'h80010);
    expect_resp(1, 28'h55, 2'd1);
    wait_idle("dalloc");
    chk("dalloc_ar", (ar_log.size() == 2) ? {ar_log[0][31:0], ar_log[1][31:0]} : 64'hDEAD, {32'h88, 32'h38});
    chk("dalloc_upd", (upd_log.size() == 1) ? 64'(upd_log[0]) : 64'hDEAD, 64'({16'h11, 28'h55}));
    chk("alloc_cnt1", {hit_cnt_o, alloc_cnt_o}, {32'd5, 32'd1});

    // Compressed entry: decompress into free way 0x42
    mem[64'h108] = (64'h99 << 12) | 64'h2;
    mem[64'h48] = 64'h42 << 12;
    free_head_i = 16'd9;
    ar_log.delete(); upd_log.delete();
    issue(3, 28'h80020);
    expect_resp(3, 28'h42, 2'd1);
    wait_idle("comp");
    chk("comp_ar", (ar_log.size() == 2) ? {ar_log[0][31:0], ar_log[1][31:0]} : 64'hDEAD, {32'h108, 32'h48});
    chk("decomp_args", 64'({dec_cppn, dec_way}), 64'({28'h99, 28'h42}));
    chk("decomp_hold", 64'({dec_unstable, 8'(dec_max_run)}), 64'h004);
    chk("comp_upd", (upd_log.size() == 1) ? 64'(upd_log[0]) : 64'hDEAD, 64'({16'h21, 28'h42}));
    chk("alloc_cnt2", 64'(alloc_cnt_o), 64'd2);

    // Empty free list: out-of-memory, then a later lookup still works
    mem[64'h188] = 64'h0;
    free_head_i = '0;
    ar_log.delete(); upd_log.delete();
    issue(0, 28'h80030);
    expect_resp(0, 28'h0, 2'd0);
    wait_idle("oom");
    chk("oom_flag", 64'(oom_o), 64'h1);
    chk("oom_no_tol", 64'({8'(ar_log.size()), 8'(upd_log.size())}), 64'h0100);
    issue(1, 28'h80001);
    expect_resp(1, 28'h100, 2'd1);
    wait_idle("after_oom");
    chk("after_oom", {16'(hit_cnt_o), 16'(alloc_cnt_o), 31'h0, oom_o}, {16'd6, 16'd2, 31'h0, 1'b1});

    // Error response on the ATT read
    err_mode = 1'b1;
    issue(2, 28'h80005);
    wait_bus_err("rresp_err");
    err_mode = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("err_stuck", 64'({ready_o, arvalid_o, rready_o, bus_err_o}), 64'b0001);
    do_reset();
    check_reset("reset1");

    // Missing read data: timeout
    mute = 1'b1;
    issue(2, 28'h80005);
    wait_bus_err("rd_timeout");
    chk("timeout_cycles", 64'(err_cyc - ack_cyc), 64'd18);
    mute = 1'b0;
    repeat (5) @(negedge clk_i);
    chk("tmo_stuck", 64'({ready_o, arvalid_o, rready_o, bus_err_o}), 64'b0001);
    do_reset();
    check_reset("reset2");

    // Recovery after reset
    issue(2, 28'h80005);
    expect_resp(2, 28'h1234, 2'd1);
    wait_idle("recover");
    chk("recover_hit", 64'(hit_cnt_o), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
